uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds bytes from N_CH requesting channels into one uart_tx.
// An owner keeps the line until its last byte, MAX_PKT bytes, or it withdraws its request.
module uart_tx_arb #(
    parameter int N_CH    = 4,
    parameter int MAX_PKT = 16,
    parameter int ACC_TO  = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_req,
    input  logic [N_CH-1:0]   i_last,
    input  logic [8*N_CH-1:0] i_data,
    output logic [N_CH-1:0]   o_ack,
    output logic [N_CH-1:0]   o_gnt,
    output logic              o_wr,
    output logic [7:0]        o_data,
    input  logic              i_txe,
    input  logic              i_txc,
    output logic              o_bsy,
    output logic              o_err
);

    localparam int PW = $clog2(N_CH);
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam int TW = $clog2(ACC_TO + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]      r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_byte_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_last;
    logic [N_CH-1:0] r_gnt;
    logic [N_CH-1:0] r_ack;
    logic            r_wr;
    logic [7:0]      r_data;
    logic            r_err;
    logic            r_bsy;

    logic [1:0]      w_state_nxt;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_pick;
    logic            w_pick_vld;
    logic [7:0]      w_own_byte;
    logic            w_own_req;
    logic            w_own_last;
    logic            w_grant;
    logic            w_send;
    logic            w_release;
    logic            w_tmo_hit;

    // Scan from the highest offset down so the nearest requester at or after rr_ptr wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = r_rr_ptr;
        w_idx      = r_rr_ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = r_rr_ptr + PW'(k);
            if (i_req[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_idx;
            end
        end
    end

    always_comb begin
        w_own_byte = 8'h00;
        for (int k = 0; k < N_CH; k++) begin
            if (r_owner == PW'(k)) begin
                w_own_byte = i_data[8*k +: 8];
            end
        end
    end

    assign w_own_req  = i_req[r_owner];
    assign w_own_last = i_last[r_owner];

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_send      = 1'b0;
        w_release   = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (!w_own_req) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (i_txe) begin
                    w_send      = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A timeout is treated exactly like the UART having taken the byte.
                w_tmo_hit = i_txe && (r_tmo == TW'(ACC_TO - 1));
                if (!i_txe || w_tmo_hit) begin
                    if (r_last || (r_byte_cnt == CW'(MAX_PKT))) begin
                        w_release   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_byte_cnt <= '0;
            r_tmo      <= '0;
            r_last     <= 1'b0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_wr       <= 1'b0;
            r_data     <= 8'h00;
            r_err      <= 1'b0;
            r_bsy      <= ~i_txc;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= '0;
            r_wr    <= 1'b0;
            r_err   <= w_tmo_hit;
            r_bsy   <= (w_state_nxt != S_IDLE) | ~i_txc;
            if (w_grant) begin
                r_owner    <= w_pick;
                r_gnt      <= N_CH'(1) << w_pick;
                r_byte_cnt <= '0;
            end
            if (w_send) begin
                r_wr           <= 1'b1;
                r_ack[r_owner] <= 1'b1;
                r_data         <= w_own_byte;
                r_last         <= w_own_last;
                r_byte_cnt     <= r_byte_cnt + 1'b1;
                r_tmo          <= '0;
            end
            if ((r_state == S_WAIT) && i_txe && !w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_release) begin
                r_gnt    <= '0;
                r_rr_ptr <= r_owner + 1'b1;
            end
        end
    end

    assign o_ack  = r_ack;
    assign o_gnt  = r_gnt;
    assign o_wr   = r_wr;
    assign o_data = r_data;
    assign o_bsy  = r_bsy;
    assign o_err  = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queued channel packets, a simple uart_tx model, and a
// packet-level round-robin reference that predicts the order of written bytes.
module tb_uart_tx_arb;

    localparam int MAX_PKT = 16;
    localparam int ACC_TO  = 64;

    logic        clk;
    logic        i_rst;
    logic [3:0]  i_req;
    logic [3:0]  i_last;
    logic [31:0] i_data;
    logic [3:0]  o_ack;
    logic [3:0]  o_gnt;
    logic        o_wr;
    logic [7:0]  o_data;
    logic        i_txe;
    logic        i_txc;
    logic        o_bsy;
    logic        o_err;

    uart_tx_arb #(.N_CH(4), .MAX_PKT(MAX_PKT), .ACC_TO(ACC_TO)) dut (
        .i_clk (clk),
        .i_rst (i_rst),
        .i_req (i_req),
        .i_last(i_last),
        .i_data(i_data),
        .o_ack (o_ack),
        .o_gnt (o_gnt),
        .o_wr  (o_wr),
        .o_data(o_data),
        .i_txe (i_txe),
        .i_txc (i_txc),
        .o_bsy (o_bsy),
        .o_err (o_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0] q_data[4][$];
    bit         q_last[4][$];
    bit         abort_m[4];
    int         exp_ch[$];
    logic [7:0] exp_d[$];
    int         m_ptr  = 0;
    int         n_wr   = 0;
    int         umode  = 0;
    int         ubusy  = 2;
    int         ucnt   = 0;
    bit         err_ok = 0;
    bit         prev_wr = 0;
    int         e_ch;
    logic [7:0] e_d;

    task automatic chk(input string tag, input bit ok);
        n_chk++;
        if (ok) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Channel sources: present the queue head, pop it once the arbiter acknowledges it.
    initial begin
        i_req  = '0;
        i_last = '0;
        i_data = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (o_ack[c] && q_data[c].size() != 0) begin
                    q_data[c].delete(0);
                    q_last[c].delete(0);
                end
                if (q_data[c].size() != 0 && !abort_m[c]) begin
                    i_req[c]          = 1'b1;
                    i_last[c]         = q_last[c][0];
                    i_data[8*c +: 8]  = q_data[c][0];
                end else begin
                    i_req[c]          = 1'b0;
                    i_last[c]         = 1'b0;
                    i_data[8*c +: 8]  = 8'h00;
                end
            end
        end
    end

    // uart_tx model: mode 0 normal, 1 never accepts (txe stuck high), 2 line busy.
    initial begin
        i_txe = 1'b1;
        i_txc = 1'b1;
        forever begin
            @(negedge clk);
            if (umode == 1) begin
                i_txe = 1'b1; i_txc = 1'b1; ucnt = 0;
            end else if (umode == 2) begin
                i_txe = 1'b0; i_txc = 1'b0; ucnt = 0;
            end else if (o_wr) begin
                ucnt = ubusy; i_txe = 1'b0; i_txc = 1'b0;
            end else if (ucnt > 1) begin
                ucnt--;
            end else begin
                ucnt = 0; i_txe = 1'b1; i_txc = 1'b1;
            end
        end
    end

    // Per-cycle output monitor and scoreboard of written bytes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("ack_vs_wr", o_ack === (o_wr ? o_gnt : 4'b0000));
            chk("bsy", o_bsy === ((o_gnt != 4'b0000) | ~i_txc));
            if (!err_ok) chk("err_idle", o_err === 1'b0);
            if (o_wr) begin
                n_wr++;
                chk("wr_gap", prev_wr === 1'b0);
                chk("gnt_onehot", $onehot(o_gnt) == 1);
                chk("exp_avail", exp_ch.size() != 0);
                if (exp_ch.size() != 0) begin
                    e_ch = exp_ch.pop_front();
                    e_d  = exp_d.pop_front();
                    chk("wr_chan", o_ack === 4'(1 << e_ch));
                    chk("wr_data", o_data === e_d);
                end
            end
            prev_wr = o_wr;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int c, input int len, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            q_data[c].push_back(rnd ? 8'($urandom) : base + 8'(i));
            q_last[c].push_back(i == len - 1);
        end
    endtask

    // Packet-level reference: serve the first channel at/after the pointer for up to
    // MAX_PKT bytes or until its last byte, then move the pointer past that channel.
    task automatic model_plan();
        logic [7:0] cd[4][$];
        bit         cl[4][$];
        int         c;
        int         n;
        bit         found;
        bit         lst;
        for (int i = 0; i < 4; i++) begin
            cd[i] = q_data[i];
            cl[i] = q_last[i];
        end
        while (1) begin
            found = 0;
            c = 0;
            for (int k = 3; k >= 0; k--) begin
                if (cd[(m_ptr + k) % 4].size() != 0) begin
                    c = (m_ptr + k) % 4;
                    found = 1;
                end
            end
            if (!found) break;
            n = 0;
            do begin
                exp_ch.push_back(c);
                exp_d.push_back(cd[c].pop_front());
                lst = cl[c].pop_front();
                n++;
            end while (!lst && n < MAX_PKT && cd[c].size() != 0);
            m_ptr = (c + 1) % 4;
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 20000 && !done; i++) begin
            step();
            done = (q_data[0].size() + q_data[1].size() + q_data[2].size() + q_data[3].size() == 0)
                && (exp_ch.size() == 0) && (o_gnt == 4'b0000) && i_txc;
        end
        chk(tag, done === 1'b1);
    endtask

    initial begin
        int  k;
        int  w0;
        bit  got;
        i_rst = 1'b1;
        repeat (3) step();
        chk("rst_gnt", o_gnt === 4'b0000);
        chk("rst_ack", o_ack === 4'b0000);
        chk("rst_wr", o_wr === 1'b0);
        chk("rst_data", o_data === 8'h00);
        chk("rst_err", o_err === 1'b0);
        chk("rst_bsy", o_bsy === 1'b0);
        i_rst = 1'b0;
        m_ptr = 0;

        // All four channels, single-byte packets, channel 0 twice.
        push_pkt(0, 1, 8'hA0, 0);
        push_pkt(1, 1, 8'hA1, 0);
        push_pkt(2, 1, 8'hA2, 0);
        push_pkt(3, 1, 8'hA3, 0);
        push_pkt(0, 1, 8'hB0, 0);
        model_plan();
        wait_idle("drain_rr");

        // Channel 1 alone sends 0x55 as a one-byte packet.
        push_pkt(1, 1, 8'h55, 0);
        model_plan();
        step();
        chk("a_gnt", o_gnt === 4'b0010);
        chk("a_nowr", o_wr === 1'b0);
        step();
        chk("a_wr", o_wr === 1'b1);
        chk("a_data", o_data === 8'h55);
        chk("a_ack", o_ack === 4'b0010);
        step();
        chk("a_release", o_gnt === 4'b0000);
        chk("a_wr_low", o_wr === 1'b0);
        chk("a_data_hold", o_data === 8'h55);
        push_pkt(1, 1, 8'h11, 0);
        push_pkt(2, 1, 8'h22, 0);
        model_plan();
        step();
        chk("rr_ptr2", o_gnt === 4'b0100);
        wait_idle("drain_a");

        // Channel 2 streams 20 bytes while channel 3 waits for its turn.
        push_pkt(2, 20, 8'h00, 0);
        push_pkt(3, 1, 8'hC3, 0);
        model_plan();
        wait_idle("drain_maxpkt");

        // UART never accepts: timeout error after ACC_TO clocks in WAIT_ACC.
        umode  = 1;
        err_ok = 1;
        push_pkt(0, 1, 8'hE7, 0);
        model_plan();
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = o_wr;
        end
        chk("to_wr_seen", got === 1'b1);
        k = 0;
        got = 0;
        for (int i = 0; i < ACC_TO + 8 && !got; i++) begin
            step();
            k++;
            got = o_err;
        end
        chk("err_latency", k == ACC_TO);
        chk("err_release", o_gnt === 4'b0000);
        step();
        chk("err_pulse", o_err === 1'b0);
        err_ok = 0;
        umode  = 0;
        wait_idle("drain_timeout");

        // Owner withdraws while the line is busy.
        umode = 2;
        push_pkt(3, 2, 8'h3C, 0);
        step();
        chk("ab_gnt", o_gnt === 4'b1000);
        step();
        step();
        chk("ab_hold_nowr", o_wr === 1'b0);
        chk("ab_hold_gnt", o_gnt === 4'b1000);
        abort_m[3] = 1;
        step();
        chk("ab_release", o_gnt === 4'b0000);
        chk("ab_nowr", o_wr === 1'b0);
        q_data[3].delete();
        q_last[3].delete();
        abort_m[3] = 0;
        m_ptr = 0;
        umode = 0;
        push_pkt(3, 1, 8'h77, 0);
        push_pkt(0, 1, 8'h66, 0);
        model_plan();
        step();
        chk("ab_next_gnt", o_gnt === 4'b0001);
        wait_idle("drain_abort");

        // Randomized traffic rounds.
        for (int r = 0; r < 4; r++) begin
            ubusy = $urandom_range(1, 6);
            for (int c = 0; c < 4; c++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    push_pkt(c, $urandom_range(1, 20), 8'h00, 1);
                end
            end
            model_plan();
            wait_idle("drain_rand");
        end

        // Reset during WAIT_ACC of the third byte of a packet.
        ubusy = 3;
        push_pkt(1, 5, 8'h80, 0);
        model_plan();
        w0 = n_wr;
        for (int i = 0; i < 200 && (n_wr - w0) < 3; i++) begin
            step();
        end
        chk("rst_reach3", (n_wr - w0) == 3);
        i_rst = 1'b1;
        q_data[1].delete();
        q_last[1].delete();
        exp_ch.delete();
        exp_d.delete();
        step();
        chk("mid_rst_gnt", o_gnt === 4'b0000);
        chk("mid_rst_ack", o_ack === 4'b0000);
        chk("mid_rst_wr", o_wr === 1'b0);
        chk("mid_rst_data", o_data === 8'h00);
        chk("mid_rst_err", o_err === 1'b0);
        chk("mid_rst_bsy", o_bsy === ~i_txc);
        i_rst = 1'b0;
        m_ptr = 0;
        push_pkt(3, 1, 8'hD3, 0);
        push_pkt(2, 1, 8'hD2, 0);
        push_pkt(0, 1, 8'hD0, 0);
        model_plan();
        step();
        chk("post_rst_gnt", o_gnt === 4'b0001);
        wait_idle("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
